// File: rtl/cpu_mem_responder_if.sv
// Request/response bus between the control unit (master) and the memory responder (slave).
interface cpu_mem_responder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  mem_select;
   logic                  mem_read_not_write;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  busy;
   logic                  error;

   modport master (
      output mem_select, mem_read_not_write, addr, wdata,
      input  rdata, ready, busy, error
   );

   modport slave (
      input  mem_select, mem_read_not_write, addr, wdata,
      output rdata, ready, busy, error
   );
endinterface

// File: rtl/cpu_mem_responder.sv
// Single-port word memory answering one CPU request at a time, with
// programmable wait states, an out-of-range flag and a one-cycle ready pulse.
module cpu_mem_responder #(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 8,
   parameter int DEPTH       = 200,
   parameter int WAIT_STATES = 2
) (
   input  logic               clk,
   input  logic               reset,
   cpu_mem_responder_if.slave bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] WAIT   = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = DEPTH[ADDR_WIDTH:0];
   localparam logic [3:0]          WAIT_INIT = WAIT_STATES[3:0];

   logic [1:0]            state;
   logic [3:0]            wait_cnt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  rnw_q;
   logic                  oor_q;
   logic                  oor_in;
   logic                  accept;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign oor_in = ({1'b0, bus.addr} >= DEPTH_LIM);
   assign accept = (state == IDLE) && bus.mem_select;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.mem_select) begin
                  if (oor_in) begin
                     state <= RESP;
                  end else if (WAIT_INIT != 4'd0) begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) state <= ACCESS;
            end
            ACCESS:  state <= RESP;
            default: state <= IDLE;
         endcase
      end
   end

   // Request capture: only IDLE samples the bus, so later input changes cannot disturb an access.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= bus.addr;
         wdata_q <= bus.wdata;
         rnw_q   <= bus.mem_read_not_write;
         oor_q   <= oor_in;
      end
   end

   // An out-of-range read returns zero immediately since it skips ACCESS.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (accept && bus.mem_read_not_write && oor_in) begin
         rdata_q <= '0;
      end else if ((state == ACCESS) && rnw_q) begin
         rdata_q <= mem[addr_q];
      end
   end

   // Reset forces IDLE asynchronously, which also blocks any pending write.
   always_ff @(posedge clk) begin
      if ((state == ACCESS) && !rnw_q) mem[addr_q] <= wdata_q;
   end

   assign bus.rdata = rdata_q;
   assign bus.ready = (state == RESP);
   assign bus.busy  = (state != IDLE);
   assign bus.error = (state == RESP) && oor_q;

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, meaning the data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the address width.
REQ-003 The block SHALL have parameter DEPTH, default 200, meaning the number of implemented words, with DEPTH ≤ 2^ADDR_WIDTH.
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, meaning the extra wait cycles per access, range 0..15.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port mem_select, input, 1 bit: request valid from the control unit.
REQ-008 The block SHALL have port mem_read_not_write, input, 1 bit: 1 = read, 0 = write.
REQ-009 The block SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-010 The block SHALL have port wdata, input, DATA_WIDTH bits: write data.
REQ-011 The block SHALL have port rdata, output, DATA_WIDTH bits: registered read data.
REQ-012 The block SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 The block SHALL have port error, output, 1 bit: out-of-range flag, valid only while ready = 1.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP, encoded in 2 bits.
REQ-016 In IDLE, when mem_select = 1 at a rising edge, the block SHALL latch addr, mem_read_not_write and wdata into internal registers.
- Next state: RESP if addr ≥ DEPTH.
- Otherwise WAIT with the wait counter loaded to WAIT_STATES, if WAIT_STATES > 0.
- Otherwise ACCESS.
REQ-017 In WAIT, the counter SHALL decrement each cycle; the FSM SHALL move to ACCESS on the edge where the counter equals 1.
REQ-018 In ACCESS, a latched read SHALL load rdata from mem[latched addr], and a latched write SHALL store latched wdata to mem[latched addr]; the next state SHALL be RESP.
REQ-019 In RESP, ready SHALL be 1 for exactly one cycle and error SHALL equal the latched out-of-range condition; the next state SHALL be IDLE unconditionally.
REQ-020 Latency: a request sampled at edge k SHALL produce ready high in the cycle following edge k+WAIT_STATES+1.
- An out-of-range request SHALL produce ready high in the cycle following edge k.
REQ-021 Inputs sampled outside IDLE SHALL be ignored; changes to addr, wdata or mem_read_not_write during WAIT or ACCESS SHALL NOT affect the access in progress.
REQ-022 If mem_select is still 1 in IDLE after RESP, a new request SHALL be accepted; the requester deasserts mem_select to avoid a re-issue.
REQ-023 An out-of-range write SHALL NOT modify any memory word; an out-of-range read SHALL load rdata with 0.
REQ-024 rdata SHALL hold its value until the next read completes; writes SHALL NOT change rdata.
REQ-025 ready, busy and error SHALL be Moore outputs decoded from state and registers only, with no combinational path from inputs.
REQ-026 The memory array SHALL be DEPTH words of DATA_WIDTH bits, with no read-during-write hazard, since one access is performed at a time.

Reset
REQ-027 While reset = 0, the FSM SHALL be forced to IDLE immediately, independent of clk, and the wait counter SHALL be 0.
REQ-028 While reset = 0, rdata SHALL be 0 and ready, busy and error SHALL be 0.
REQ-029 Reset asserted mid-access SHALL abort the access; a write aborted before ACCESS completes SHALL leave memory unchanged.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset deassertion SHALL take effect at the first rising edge after reset returns to 1; no request SHALL be accepted while reset = 0.

Verification
REQ-032 Write then read (WAIT_STATES = 2): write addr 8'h10 with 16'hBEEF, then read addr 8'h10 -> each ready pulse 3 edges after acceptance, and rdata = 16'hBEEF in the read's RESP cycle.
REQ-033 Out-of-range access (DEPTH = 200): write addr 8'd220 with 16'h1234, then read addr 8'd220 -> ready and error pulse the cycle after acceptance, rdata = 0, and memory is unchanged.
REQ-034 Zero wait states (WAIT_STATES = 0): read addr 8'h00 preloaded with 16'h0042 -> ready 1 edge after acceptance and rdata = 16'h0042.
REQ-035 Input change in WAIT: change addr from 8'h05 to 8'h06 and wdata to 16'hFFFF during WAIT -> only mem[8'h05] receives the originally latched data.
REQ-036 Reset mid-write: assert reset during WAIT of a write to 8'h20 -> busy drops to 0 at once, a later read of 8'h20 returns its prior value, and ready is never pulsed for the aborted write.
REQ-037 Held mem_select: hold mem_select = 1 across RESP -> a second access starts in the cycle after RESP, and the busy gap is one IDLE cycle.
